// File: rtl/pmci_bridge_pkg.sv
// Shared types for the PMCI host MMIO-to-AVMM bridge: FSM states, beat size, response record.
package pmci_bridge_pkg;

    localparam int BEAT_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_LO_DATA,
        RD_HI,
        RD_HI_DATA,
        RSP
    } bridge_state_e;

    typedef struct packed {
        logic [63:0] rdata;
        logic [7:0]  tag;
        logic        err;
    } rsp_t;

    // A 64-bit access must be 8-byte aligned, a 32-bit access 4-byte aligned.
    function automatic logic is_misaligned(input logic len64, input logic [2:0] addr_lsb);
        return len64 ? (addr_lsb != 3'b000) : (addr_lsb[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pmci_bridge_timer.sv
// Per-beat stall counter; expired is high on the LIMIT-th consecutive run cycle after start.
// No latency beyond that count; it never backpressures anything.
module pmci_bridge_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic start,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear || start) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/pmci_host_avmm_bridge.sv
// MMIO to 32-bit AVMM bridge, one request at a time; 64-bit accesses split into two beats, 3-cycle min read latency.
// Ready only in IDLE, response held until mmio_rsp_ready; PMCI_BRIDGE_TIMEOUT_EN adds a per-beat stall timeout.
module pmci_host_avmm_bridge
    import pmci_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mmio_req_valid,
    output logic              mmio_req_ready,
    input  logic              mmio_req_write,
    input  logic              mmio_req_len64,
    input  logic [ADDR_W-1:0] mmio_req_addr,
    input  logic [63:0]       mmio_req_wdata,
    input  logic [7:0]        mmio_req_tag,

    output logic              mmio_rsp_valid,
    input  logic              mmio_rsp_ready,
    output logic [63:0]       mmio_rsp_rdata,
    output logic [7:0]        mmio_rsp_tag,
    output logic              mmio_rsp_err,

    output logic [ADDR_W-1:0] avmm_address,
    output logic              avmm_write,
    output logic              avmm_read,
    output logic [31:0]       avmm_writedata,
    output logic [3:0]        avmm_byteenable,
    input  logic              avmm_waitrequest,
    input  logic [31:0]       avmm_readdata,
    input  logic              avmm_readdatavalid
);

    bridge_state_e     state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_hi;
    logic [63:0]       wdata_q;
    logic              len64_q;
    rsp_t              rsp_q;
    logic              accept;
    logic              misalign;
    logic              rd_abort;
    logic              timeout;

    assign accept   = mmio_req_valid && mmio_req_ready;
    assign misalign = is_misaligned(mmio_req_len64, mmio_req_addr[2:0]);
    // Natural truncation gives the modulo-2^ADDR_W wrap for the high beat.
    assign addr_hi  = addr_q + ADDR_W'(BEAT_BYTES);

`ifdef PMCI_BRIDGE_TIMEOUT_EN
    logic waiting;

    assign waiting = (state == WR_LO) || (state == WR_HI) || (state == RD_LO) ||
                     (state == RD_LO_DATA) || (state == RD_HI) || (state == RD_HI_DATA);

    // Every state change restarts the count, so each beat gets its own budget.
    pmci_bridge_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .start   (state_next != state),
        .run     (waiting),
        .clear   (rst),
        .expired (timeout)
    );
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        mmio_req_ready = 1'b0;
        mmio_rsp_valid = 1'b0;
        avmm_write     = 1'b0;
        avmm_read      = 1'b0;
        avmm_address   = addr_q;
        avmm_writedata = wdata_q[31:0];
        rd_abort       = 1'b0;

        case (state)
            IDLE: begin
                mmio_req_ready = 1'b1;
                if (mmio_req_valid) begin
                    if (misalign) begin
                        state_next = mmio_req_write ? IDLE : RSP;
                    end else begin
                        state_next = mmio_req_write ? WR_LO : RD_LO;
                    end
                end
            end
            WR_LO: begin
                avmm_write = 1'b1;
                if (!avmm_waitrequest) begin
                    state_next = len64_q ? WR_HI : IDLE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            WR_HI: begin
                avmm_write     = 1'b1;
                avmm_address   = addr_hi;
                avmm_writedata = wdata_q[63:32];
                if (!avmm_waitrequest || timeout) begin
                    state_next = IDLE;
                end
            end
            RD_LO: begin
                avmm_read = 1'b1;
                if (!avmm_waitrequest) begin
                    state_next = RD_LO_DATA;
                end else if (timeout) begin
                    state_next = RSP;
                    rd_abort   = 1'b1;
                end
            end
            RD_LO_DATA: begin
                if (avmm_readdatavalid) begin
                    state_next = len64_q ? RD_HI : RSP;
                end else if (timeout) begin
                    state_next = RSP;
                    rd_abort   = 1'b1;
                end
            end
            RD_HI: begin
                avmm_read    = 1'b1;
                avmm_address = addr_hi;
                if (!avmm_waitrequest) begin
                    state_next = RD_HI_DATA;
                end else if (timeout) begin
                    state_next = RSP;
                    rd_abort   = 1'b1;
                end
            end
            RD_HI_DATA: begin
                if (avmm_readdatavalid) begin
                    state_next = RSP;
                end else if (timeout) begin
                    state_next = RSP;
                    rd_abort   = 1'b1;
                end
            end
            RSP: begin
                mmio_rsp_valid = 1'b1;
                if (mmio_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset takes effect on the bus immediately, not one edge later.
        if (rst) begin
            mmio_req_ready = 1'b0;
            mmio_rsp_valid = 1'b0;
            avmm_write     = 1'b0;
            avmm_read      = 1'b0;
            rd_abort       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            len64_q <= 1'b0;
            rsp_q   <= '0;
        end else begin
            if (accept) begin
                addr_q      <= mmio_req_addr;
                wdata_q     <= mmio_req_wdata;
                len64_q     <= mmio_req_len64;
                rsp_q.tag   <= mmio_req_tag;
                rsp_q.rdata <= '0;
                rsp_q.err   <= misalign;
            end
            if (state == RD_LO_DATA && avmm_readdatavalid) begin
                rsp_q.rdata[31:0] <= avmm_readdata;
            end
            if (state == RD_HI_DATA && avmm_readdatavalid) begin
                rsp_q.rdata[63:32] <= avmm_readdata;
            end
            // An abandoned read discards any half-captured data.
            if (rd_abort) begin
                rsp_q.rdata <= '0;
                rsp_q.err   <= 1'b1;
            end
        end
    end

    assign mmio_rsp_rdata  = rsp_q.rdata;
    assign mmio_rsp_tag    = rsp_q.tag;
    assign mmio_rsp_err    = rsp_q.err;
    assign avmm_byteenable = 4'hF;

endmodule

// File: tb/tb_pmci_host_avmm_bridge.sv
// Bench for pmci_host_avmm_bridge: directed scenarios then randomized traffic against a word-memory model.
module tb_pmci_host_avmm_bridge;

    localparam int ADDR_W = 32;
    localparam int TMO    = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mmio_req_valid = 1'b0;
    logic        mmio_req_ready;
    logic        mmio_req_write = 1'b0;
    logic        mmio_req_len64 = 1'b0;
    logic [31:0] mmio_req_addr  = '0;
    logic [63:0] mmio_req_wdata = '0;
    logic [7:0]  mmio_req_tag   = '0;
    logic        mmio_rsp_valid;
    logic        mmio_rsp_ready = 1'b0;
    logic [63:0] mmio_rsp_rdata;
    logic [7:0]  mmio_rsp_tag;
    logic        mmio_rsp_err;
    logic [31:0] avmm_address;
    logic        avmm_write;
    logic        avmm_read;
    logic [31:0] avmm_writedata;
    logic [3:0]  avmm_byteenable;
    logic        avmm_waitrequest   = 1'b0;
    logic [31:0] avmm_readdata      = '0;
    logic        avmm_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    pmci_host_avmm_bridge #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mmio_req_valid     (mmio_req_valid),
        .mmio_req_ready     (mmio_req_ready),
        .mmio_req_write     (mmio_req_write),
        .mmio_req_len64     (mmio_req_len64),
        .mmio_req_addr      (mmio_req_addr),
        .mmio_req_wdata     (mmio_req_wdata),
        .mmio_req_tag       (mmio_req_tag),
        .mmio_rsp_valid     (mmio_rsp_valid),
        .mmio_rsp_ready     (mmio_rsp_ready),
        .mmio_rsp_rdata     (mmio_rsp_rdata),
        .mmio_rsp_tag       (mmio_rsp_tag),
        .mmio_rsp_err       (mmio_rsp_err),
        .avmm_address       (avmm_address),
        .avmm_write         (avmm_write),
        .avmm_read          (avmm_read),
        .avmm_writedata     (avmm_writedata),
        .avmm_byteenable    (avmm_byteenable),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // ---------------- AVMM slave with memory, stalls and read latency ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       blog[$];
    logic [31:0] smem [logic [31:0]];
    logic [31:0] mdl  [logic [31:0]];
    int          stall_cfg  = 0;
    int          stall_left = 0;
    int          rdv_delay  = 1;
    int          rdv_cnt    = 0;
    int          stall_seen = 0;
    logic [31:0] rdv_dat    = '0;
    logic        stuck_en   = 1'b0;
    logic [31:0] stuck_addr = '0;
    logic        prev_stall = 1'b0;
    logic [65:0] prev_bus   = '0;
    int          rsp_cnt    = 0;

    always @(negedge clk) begin
        logic spur;
        spur = (rdv_cnt == 0) && ($urandom_range(0, 7) == 0);
        avmm_readdatavalid = 1'b0;
        avmm_readdata      = $urandom;
        if (rdv_cnt > 0) begin
            rdv_cnt--;
            if (rdv_cnt == 0) begin
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = rdv_dat;
            end
        end else if (spur) begin
            avmm_readdatavalid = 1'b1;
        end
        if (rst) begin
            avmm_waitrequest = 1'b0;
            prev_stall       = 1'b0;
            rdv_cnt          = 0;
        end else begin
            if (prev_stall) begin
                chk("avmm_held_during_stall", {avmm_write, avmm_read, avmm_address, avmm_writedata}, prev_bus);
            end
            if (avmm_write || avmm_read) begin
                if ((stuck_en && avmm_address == stuck_addr) || stall_left > 0) begin
                    avmm_waitrequest = 1'b1;
                    if (stall_left > 0) stall_left--;
                    stall_seen++;
                    prev_stall = 1'b1;
                    prev_bus   = {avmm_write, avmm_read, avmm_address, avmm_writedata};
                end else begin
                    avmm_waitrequest = 1'b0;
                    prev_stall       = 1'b0;
                    if (avmm_write) begin
                        smem[avmm_address] = avmm_writedata;
                        blog.push_back({1'b1, avmm_address, avmm_writedata});
                    end else begin
                        rdv_dat = smem.exists(avmm_address) ? smem[avmm_address] : 32'h0;
                        rdv_cnt = rdv_delay;
                        blog.push_back({1'b0, avmm_address, rdv_dat});
                    end
                    stall_left = stall_cfg;
                end
            end else begin
                avmm_waitrequest = 1'b0;
                prev_stall       = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && mmio_rsp_valid && mmio_rsp_ready) rsp_cnt++;
    end

    // ---------------- MMIO host tasks ----------------
    task automatic send_req(input logic wr, input logic l64, input logic [31:0] a,
                            input logic [63:0] wd, input logic [7:0] tg);
        int n;
        n = 0;
        @(posedge clk); #1;
        mmio_req_valid = 1'b1;
        mmio_req_write = wr;
        mmio_req_len64 = l64;
        mmio_req_addr  = a;
        mmio_req_wdata = wd;
        mmio_req_tag   = tg;
        @(negedge clk);
        while (!mmio_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_accepted_in_time", (n < 200), 1'b1);
        @(posedge clk); #1;
        mmio_req_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output logic [63:0] rd, output logic [7:0] tg,
                           output logic er, output int lat);
        int k;
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (mmio_rsp_valid) break;
        end
        lat = k;
        rd  = mmio_rsp_rdata;
        tg  = mmio_rsp_tag;
        er  = mmio_rsp_err;
        chk("rsp_arrives", mmio_rsp_valid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_hold_valid", mmio_rsp_valid, 1'b1);
            chk("rsp_hold_fields", {mmio_rsp_rdata, mmio_rsp_tag, mmio_rsp_err}, {rd, tg, er});
            chk("rsp_hold_req_ready", mmio_req_ready, 1'b0);
        end
        @(posedge clk); #1;
        mmio_rsp_ready = 1'b1;
        @(posedge clk); #1;
        mmio_rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!mmio_req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("returns_to_idle", mmio_req_ready, 1'b1);
    endtask

    task automatic cfg_slave(input int stall, input int rdv);
        stall_cfg  = stall;
        stall_left = stall;
        rdv_delay  = rdv;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] rd, exp_rd;
        logic [7:0]  tg;
        logic        er, wr, l64, misal;
        logic [31:0] a;
        logic [63:0] wd;
        int          lat, rc, n;
        beat_t       exp_b[$];

        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom;
            smem[32'(i * 4)] = v;
            mdl[32'(i * 4)]  = v;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("ready_low_in_reset", mmio_req_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", mmio_req_ready, 1'b1);
        chk("post_reset_outputs", {mmio_rsp_valid, avmm_write, avmm_read, avmm_byteenable}, {3'b000, 4'hF});
        chk("post_reset_regs", {mmio_rsp_rdata, mmio_rsp_tag, mmio_rsp_err, avmm_address}, '0);

        // Write64, no stall
        cfg_slave(0, 1);
        blog.delete();
        rc = rsp_cnt;
        send_req(1'b1, 1'b1, 32'h20, 64'hBAADBEEF_12345678, 8'h11);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("wr64_beats", blog.size(), 2);
        chk("wr64_beat_lo", blog[0], {1'b1, 32'h20, 32'h12345678});
        chk("wr64_beat_hi", blog[1], {1'b1, 32'h24, 32'hBAADBEEF});
        chk("wr64_no_rsp", rsp_cnt - rc, 0);
        mdl[32'h20] = 32'h12345678;
        mdl[32'h24] = 32'hBAADBEEF;

        // Read64 with 5 stall cycles per beat
        cfg_slave(5, 2);
        blog.delete();
        stall_seen = 0;
        send_req(1'b0, 1'b1, 32'h20, 64'h0, 8'h5A);
        get_rsp(0, rd, tg, er, lat);
        chk("rd64_data", rd, 64'hBAADBEEF_12345678);
        chk("rd64_err", er, 1'b0);
        chk("rd64_tag", tg, 8'h5A);
        chk("rd64_stall_cycles", stall_seen, 10);
        chk("rd64_beat_addrs", {blog[0].addr, blog[1].addr}, {32'h20, 32'h24});

        // Misaligned read32
        cfg_slave(0, 1);
        blog.delete();
        send_req(1'b0, 1'b0, 32'h1D, 64'h0, 8'hC3);
        get_rsp(0, rd, tg, er, lat);
        chk("misal_rd_no_beat", blog.size(), 0);
        chk("misal_rd_rsp", {rd, tg, er}, {64'h0, 8'hC3, 1'b1});

        // Read32 with response backpressure
        rc = rsp_cnt;
        send_req(1'b0, 1'b0, 32'h30, 64'h0, 8'h42);
        get_rsp(10, rd, tg, er, lat);
        chk("bp_rd_rsp", {rd, tg, er}, {32'h0, mdl[32'h30], 8'h42, 1'b0});
        @(negedge clk);
        chk("bp_single_completion", rsp_cnt - rc, 1);
        chk("bp_valid_drops", mmio_rsp_valid, 1'b0);

        // Minimum read latency
        cfg_slave(0, 1);
        send_req(1'b0, 1'b0, 32'h34, 64'h0, 8'h07);
        get_rsp(0, rd, tg, er, lat);
        chk("min_latency", lat, 3);
        chk("min_latency_data", rd, {32'h0, mdl[32'h34]});

        // Misaligned 64-bit write is dropped
        blog.delete();
        rc = rsp_cnt;
        send_req(1'b1, 1'b1, 32'h44, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
        wait_idle();
        chk("misal_wr_dropped", {blog.size(), rsp_cnt - rc}, {32'd0, 32'd0});

        // Reset during the high write beat's stall
        blog.delete();
        stuck_en   = 1'b1;
        stuck_addr = 32'h4C;
        send_req(1'b1, 1'b1, 32'h48, 64'h0BAD0BAD_CAFEF00D, 8'h00);
        n = 0;
        while (!(avmm_write && avmm_address == 32'h4C) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wr_hi", {avmm_write, avmm_address}, {1'b1, 32'h4C});
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_strobes_low", {avmm_write, avmm_read, mmio_rsp_valid}, 3'b000);
        @(posedge clk); #1;
        rst      = 1'b0;
        stuck_en = 1'b0;
        @(negedge clk);
        chk("rst_accept_next_cycle", mmio_req_ready, 1'b1);
        mdl[32'h48] = 32'hCAFEF00D;
        send_req(1'b0, 1'b1, 32'h48, 64'h0, 8'h99);
        get_rsp(0, rd, tg, er, lat);
        chk("post_rst_rd", {rd, tg, er}, {mdl[32'h4C], 32'hCAFEF00D, 8'h99, 1'b0});

        // Randomized traffic against the memory model
        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            l64 = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            wd  = {$urandom, $urandom};
            tg  = 8'($urandom);
            misal = l64 ? (a[2:0] != 3'b0) : (a[1:0] != 2'b0);
            exp_b.delete();
            if (!misal) begin
                exp_b.push_back({wr, a, wr ? wd[31:0] : mdl[a]});
                if (l64) exp_b.push_back({wr, a + 32'd4, wr ? wd[63:32] : mdl[a + 32'd4]});
            end
            cfg_slave($urandom_range(0, 3), $urandom_range(1, 3));
            blog.delete();
            rc = rsp_cnt;
            send_req(wr, l64, a, wd, tg);
            if (wr) begin
                wait_idle();
                chk("rnd_wr_no_rsp", rsp_cnt - rc, 0);
                if (!misal) begin
                    mdl[a] = wd[31:0];
                    if (l64) mdl[a + 32'd4] = wd[63:32];
                end
            end else begin
                get_rsp($urandom_range(0, 2), rd, tg, er, lat);
                exp_rd = misal ? 64'h0 : {l64 ? mdl[a + 32'd4] : 32'h0, mdl[a]};
                chk("rnd_rd_rsp", {rd, er}, {exp_rd, misal});
                chk("rnd_rd_tag", tg, mmio_req_tag);
            end
            chk("rnd_beat_count", blog.size(), exp_b.size());
            for (int i = 0; i < exp_b.size() && i < blog.size(); i++) begin
                chk("rnd_beat", blog[i], exp_b[i]);
            end
        end

        // Waitrequest stuck high
        cfg_slave(0, 1);
        stuck_en   = 1'b1;
        stuck_addr = 32'h40;
        send_req(1'b0, 1'b0, 32'h40, 64'h0, 8'h77);
`ifdef PMCI_BRIDGE_TIMEOUT_EN
        get_rsp(0, rd, tg, er, lat);
        chk("tmo_rsp", {rd, tg, er}, {64'h0, 8'h77, 1'b1});
        chk("tmo_latency_window", (lat >= TMO) && (lat <= TMO + 2), 1'b1);
`else
        rc = rsp_cnt;
        repeat (TMO + 50) @(negedge clk);
        chk("no_tmo_still_waiting", {mmio_rsp_valid, avmm_read, avmm_address}, {1'b0, 1'b1, 32'h40});
        chk("no_tmo_no_rsp", rsp_cnt - rc, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        stuck_en = 1'b0;
        send_req(1'b0, 1'b0, 32'h38, 64'h0, 8'h3C);
        get_rsp(0, rd, tg, er, lat);
        chk("after_stuck_rd", {rd, tg, er}, {32'h0, mdl[32'h38], 8'h3C, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmci_host_avmm_bridge.md
PMCI_HOST_AVMM_BRIDGE -- requirements
Module: pmci_host_avmm_bridge

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32; MMIO and AVMM byte-address width.
- REQ-002 SHALL have parameter TIMEOUT_CYC, default 256; waitrequest or readdatavalid cycle limit, used only when timeout is compiled in.
- REQ-003 SHALL have clock and reset ports as follows: one clock; reset is synchronous and active-high.
  - clk  in  1  bridge clock.
  - rst  in  1  synchronous active-high reset.
- REQ-004 SHALL have the MMIO request ports:
  - mmio_req_valid  in  1  request present.
  - mmio_req_ready  out  1  request accepted this cycle when valid&ready.
  - mmio_req_write  in  1  1=write, 0=read.
  - mmio_req_len64  in  1  1=64-bit access, 0=32-bit access.
  - mmio_req_addr  in  ADDR_W  byte address.
  - mmio_req_wdata  in  64  write data; [31:0] only for 32-bit.
  - mmio_req_tag  in  8  read tag.
- REQ-005 SHALL have the MMIO response ports:
  - mmio_rsp_valid  out  1  read completion present.
  - mmio_rsp_ready  in  1  completion consumed.
  - mmio_rsp_rdata  out  64  read data; [63:32]=0 for 32-bit reads.
  - mmio_rsp_tag  out  8  echoed tag.
  - mmio_rsp_err  out  1  unsuccessful completion.
- REQ-006 SHALL have the AVMM master ports, toward pmci_csr host slave:
  - avmm_address  out  ADDR_W  address.
  - avmm_write  out  1  write strobe.
  - avmm_read  out  1  read strobe.
  - avmm_writedata  out  32  write data.
  - avmm_byteenable  out  4  byte enables; always 4'hF.
  - avmm_waitrequest  in  1  slave stall.
  - avmm_readdata  in  32  read data.
  - avmm_readdatavalid  in  1  read data strobe.

Function
- REQ-007 SHALL accept one request at a time; mmio_req_ready=1 only in IDLE.
- REQ-008 SHALL use FSM states IDLE, WR_LO, WR_HI, RD_LO, RD_LO_DATA, RD_HI, RD_HI_DATA, RSP.
- REQ-009 SHALL, on accept, register address/data/tag and move to WR_LO (write) or RD_LO (read) the next cycle.
- REQ-010 SHALL hold avmm_address, avmm_writedata, avmm_write and avmm_read stable while avmm_waitrequest=1; a beat completes on the first cycle with strobe=1 and waitrequest=0.
- REQ-011 SHALL issue a 64-bit access as two beats: low at addr with data[31:0], then high at addr+4 with data[63:32]; a 32-bit access SHALL issue the low beat only.
- REQ-012 SHALL deassert the read strobe after the accepted beat and capture avmm_readdata on avmm_readdatavalid in RD_x_DATA.
- REQ-013 SHALL ignore readdatavalid outside RD_x_DATA.
- REQ-014 SHALL post writes, producing no response, and return to IDLE after the last beat.
- REQ-015 SHALL, in RSP, drive mmio_rsp_valid=1 with data, tag and err stable until mmio_rsp_ready=1, then go to IDLE.
- REQ-016 SHALL flag a 64-bit request with addr[2:0]!=0, or a 32-bit request with addr[1:0]!=0, as misaligned and issue no AVMM beat.
  - Misaligned write: dropped.
  - Misaligned read: go directly to RSP with err=1, rdata=0.
- REQ-017 SHALL compute addr+4 modulo 2^ADDR_W, wrapping silently.
- REQ-018 SHALL give a minimum latency of 3 cycles from accept to mmio_rsp_valid for a 32-bit read with zero waitrequest and readdatavalid one cycle after the strobe.

Reset
- REQ-019 SHALL, while rst=1, force the FSM to IDLE, all strobes and mmio_rsp_valid to 0, and the data/address/tag registers to 0, including when reset is asserted mid-transaction.
- REQ-020 SHALL drop any in-flight transaction silently on reset.
- REQ-021 SHALL make the first accept possible the cycle after rst deasserts.

Configuration
- REQ-022 SHALL, with PMCI_BRIDGE_TIMEOUT_EN defined, count cycles per beat (waitrequest stall or data wait) and on reaching TIMEOUT_CYC:
  - deassert strobes;
  - complete a read with err=1, rdata=0;
  - abandon a write;
  - return to IDLE or RSP.
- REQ-023 SHALL, without PMCI_BRIDGE_TIMEOUT_EN, omit the counter and wait indefinitely.

Structure
- REQ-024 SHALL take the FSM state enum, the BEAT_BYTES=4 constant and the response struct from shared package pmci_bridge_pkg.
- REQ-025 SHALL place the timeout counter in a sub-module pmci_bridge_timer (inputs: start, run, clear; output: expired), instantiated only under the macro.

Verification
- REQ-026 Write64 0xBAADBEEF_12345678 to 0x20, no stall -> writes 0x12345678@0x20 then 0xBAADBEEF@0x24; no response.
- REQ-027 Read64 @0x20, waitrequest high 5 cycles per beat -> address and strobe held stable; rsp rdata=0xBAADBEEF_12345678, err=0, tag echoed.
- REQ-028 Read32 @0x1D -> no AVMM access; rsp err=1, rdata=0.
- REQ-029 Read32 with mmio_rsp_ready low 10 cycles -> rsp held stable, ready=0 throughout, single completion.
- REQ-030 rst pulsed during WR_HI stall -> strobes 0 next cycle; a new read afterwards completes correctly.
- REQ-031 With PMCI_BRIDGE_TIMEOUT_EN, waitrequest stuck high -> err completion after TIMEOUT_CYC=256 cycles; without the macro, no completion.
